// File: rtl/mul_div_unit.sv
`default_nettype none
// =============================================================================
// mul_div_unit : iterative RV32M multiply/divide, one shift-add or restoring
//                divide step per cycle, valid/ready request and result ports.
// Revision     : 1.0
// =============================================================================
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             startValid,
  output logic             startReady,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [4:0]       destAddr,
  output logic             resultValid,
  input  logic             resultReady,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       resultAddr,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] C_INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [4:0]         addr_q, addr_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   res_q, res_d;

  logic               is_div, a_signed, b_signed, sign_a, sign_b;
  logic               div_zero, div_ovf, div_ok;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rem, sel;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;

  assign is_div   = op_q[2];
  assign a_signed = is_div ? ~op_q[0] : (op_q == 3'b001) | (op_q == 3'b010);
  assign b_signed = is_div ? ~op_q[0] : (op_q == 3'b001);
  assign sign_a   = a_signed & a_q[WIDTH-1];
  assign sign_b   = b_signed & b_q[WIDTH-1];
  assign mag_a    = sign_a ? -a_q : a_q;
  assign mag_b    = sign_b ? -b_q : b_q;
  assign div_zero = is_div & (b_q == '0);
  assign div_ovf  = is_div & ~op_q[0] & (a_q == C_INT_MIN) & (b_q == '1);

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits / quotient bits}, shifted left.
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = {1'b0, div_shift} - {2'b00, b_q};
  assign div_ok    = ~div_diff[WIDTH+1];
  assign div_next  = div_ok ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  assign prod_fix = neg_q  ? -acc_q : acc_q;
  assign quo      = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem      = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    case (op_q)
      3'b000:          sel = prod_fix[WIDTH-1:0];
      3'b100, 3'b101:  sel = quo;
      3'b110, 3'b111:  sel = rem;
      default:         sel = prod_fix[2*WIDTH-1:WIDTH];
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (startValid) begin
          op_d    = funct3;
          a_d     = operandA;
          b_d     = operandB;
          addr_d  = destAddr;
          state_d = PREP;
        end
      end
      PREP: begin
        if (div_zero) begin
          res_d   = op_q[1] ? a_q : '1;
          state_d = DONE;
        end else if (div_ovf) begin
          res_d   = op_q[1] ? '0 : C_INT_MIN;
          state_d = DONE;
        end else begin
          a_d     = mag_a;
          b_d     = mag_b;
          acc_d   = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
          neg_d   = sign_a ^ sign_b;
          rneg_d  = sign_a;
          cnt_d   = 5'd31;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = is_div ? div_next : mul_next;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        res_d   = sel;
        state_d = DONE;
      end
      DONE: begin
        if (resultReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      addr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
    end
  end

  // Outputs read as idle for the whole time reset is held, not only after the edge.
  assign startReady  = reset | (state_q == IDLE);
  assign busy        = ~reset & (state_q != IDLE);
  assign resultValid = ~reset & (state_q == DONE);
  assign result      = reset ? '0 : res_q;
  assign resultAddr  = reset ? '0 : addr_q;

endmodule
`default_nettype wire
